// File: rtl/weight_fetch_pkg.sv
// Shared types and sizing for the weight ROM fetcher and its output FIFO.
package weight_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

endpackage

// File: rtl/weight_skid_fifo.sv
// Small FIFO of {last, data} entries sitting between the ROM read path and
// the downstream stream; head is the oldest entry, count its occupancy.
module weight_skid_fifo
  import weight_fetch_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [WIDTH-1:0]      head
);

  localparam logic [FIFO_CNT_W-1:0] FULL = FIFO_CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [FIFO_PTR_W-1:0] next_ptr(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_fetcher.sv
// Sweeps a contiguous ROM address range and streams the returned words out
// as valid/ready beats with a last flag, buffering against backpressure.
module weight_fetcher
  import weight_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_r_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int ENTRY_W = DATA_WIDTH + 1;
  localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  issued_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  inflight;
  logic                  inflight_last;
  logic                  pop;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   occupancy;
  logic [ENTRY_W-1:0]    head;

  weight_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data({inflight_last, rom_data}),
    .pop      (pop),
    .count    (fifo_count),
    .head     (head)
  );

  assign m_valid = (fifo_count != '0);
  assign {m_last, m_data} = head;
  assign pop = m_valid && m_ready;

  // Occupancy after this edge counting the read already in flight; a new read
  // is only issued when its word is guaranteed a FIFO slot.
  assign occupancy = {1'b0, fifo_count}
                   + {{FIFO_CNT_W{1'b0}}, inflight}
                   - {{FIFO_CNT_W{1'b0}}, pop};

  assign issued_nxt = issued + 1'b1;
  assign addr_next  = base_q + issued[ADDR_WIDTH-1:0];
  assign rom_r_en   = (state == FETCH) && (issued < len_q) && (occupancy < OCC_LIMIT);
  assign rom_addr   = rom_r_en ? addr_next : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      addr_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= rom_r_en;
      if (rom_r_en) begin
        inflight_last <= (issued_nxt == len_q);
        issued        <= issued_nxt;
        addr_q        <= addr_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= FETCH;
              busy   <= 1'b1;
              base_q <= base_addr;
              len_q  <= length;
              issued <= '0;
            end
          end
        end
        FETCH: begin
          if (issued == len_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((fifo_count == '0) && !inflight) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
